seq_divider: RTL and testbench

//   Sequential restoring divider: DW-bit unsigned dividend / VW-bit unsigned divisor.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 85 ++++++++
 tb/tb_seq_divider.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider.
// Latency: none (wiring only).
// Backpressure: master holds start until ready is seen high at a clock edge.
interface seq_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          ready;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
// Latency: DW cycles from accept to ready; divide-by-zero resolves at the accept edge.
// Backpressure: ready=0 while busy; start is ignored (not queued) until ready returns.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(DW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] dvd_q;   // dividend, shifted left so the next bit is always the MSB
    logic [VW-1:0] dvs_q;
    logic [VW-1:0] r_q;     // stored partial remainder, always < divisor
    logic [DW-1:0] q_q;     // quotient bits collected so far
    logic [CW-1:0] cnt;

    logic [VW:0]   r_shift;
    logic [VW-1:0] diff;
    logic          ge;
    logic [VW-1:0] r_next;
    logic [DW-1:0] q_next;
    logic          accept;

    assign bus.ready = (state != S_BUSY);
    assign accept    = bus.ready && bus.start;

    // One restoring step: bring in the next dividend bit, subtract when it fits.
    // When ge holds the difference is below 2^VW, so a VW-bit subtract is exact.
    always_comb begin
        r_shift = {r_q, dvd_q[DW-1]};
        ge      = (r_shift >= {1'b0, dvs_q});
        diff    = r_shift[VW-1:0] - dvs_q;
        r_next  = ge ? diff : r_shift[VW-1:0];
        q_next  = {q_q[DW-2:0], ge};
    end

    // Control, working registers and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            dvd_q           <= '0;
            dvs_q           <= '0;
            r_q             <= '0;
            q_q             <= '0;
            cnt             <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (accept) begin
            if (bus.divisor == '0) begin
                // No iteration needed: result is defined immediately.
                state           <= S_DONE;
                bus.quotient    <= '1;
                bus.remainder   <= '0;
                bus.div_by_zero <= 1'b1;
            end else begin
                state           <= S_BUSY;
                dvd_q           <= bus.dividend;
                dvs_q           <= bus.divisor;
                r_q             <= '0;
                q_q             <= '0;
                cnt             <= CW'(DW);
                bus.div_by_zero <= 1'b0;
            end
        end else if (state == S_BUSY) begin
            dvd_q <= {dvd_q[DW-2:0], 1'b0};
            r_q   <= r_next;
            q_q   <= q_next;
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state         <= S_DONE;
                bus.quotient  <= q_next;
                bus.remainder <= r_next;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (8/4 sizing) with hand-computed expectations.
// Latency: checks ready stays low exactly 8 cycles after accept.
// Backpressure: exercises ignored start while busy and start held high.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.DW(8), .VW(4)) bus ();

    seq_divider #(.DW(8), .VW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ready is seen high again.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int cyc);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("ready_after_%0d/%0d", a, b), 32'(bus.ready), 32'd1);
    endtask

    task automatic check_res(input string tag, input logic [7:0] q, input logic [3:0] r, input logic z);
        check({tag, "_q"},   32'(bus.quotient),    32'(q));
        check({tag, "_r"},   32'(bus.remainder),   32'(r));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(z));
    endtask

    typedef struct { logic [7:0] a; logic [3:0] b; logic [7:0] q; logic [3:0] r; } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cyc;
        bit   stuck;
        vec_t edges [4];
        edges[0] = '{8'd255, 4'd1,  8'd255, 4'd0};
        edges[1] = '{8'd7,   4'd15, 8'd0,   4'd7};
        edges[2] = '{8'd255, 4'd15, 8'd17,  4'd0};
        edges[3] = '{8'd0,   4'd5,  8'd0,   4'd0};

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(bus.ready), 32'd1);
        check_res("reset", 8'd0, 4'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // 1: basic operation and latency
        run_op(8'd105, 4'd9, cyc);
        check("t1_latency", 32'(cyc), 32'd8);
        check_res("t1", 8'd11, 4'd6, 1'b0);

        // 2: edge values
        foreach (edges[i]) begin
            run_op(edges[i].a, edges[i].b, cyc);
            check_res($sformatf("t2_%0d/%0d", edges[i].a, edges[i].b), edges[i].q, edges[i].r, 1'b0);
        end

        // 3: divide by zero resolves at the accept edge, ready never drops
        bus.dividend = 8'd200;
        bus.divisor  = 4'd0;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("t3_ready", 32'(bus.ready), 32'd1);
        check_res("t3_dbz", 8'd255, 4'd0, 1'b1);
        run_op(8'd50, 4'd7, cyc);
        check_res("t3_after", 8'd7, 4'd1, 1'b0);

        // 4: start while busy is ignored; old results held during busy
        bus.dividend = 8'd100;
        bus.divisor  = 4'd3;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.dividend = 8'd9;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4_busy_ready", 32'(bus.ready), 32'd0);
        check_res("t4_held", 8'd7, 4'd1, 1'b0);
        cyc = 0;
        while (!bus.ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_latency_rest", 32'(cyc), 32'd5);
        check_res("t4", 8'd33, 4'd1, 1'b0);

        // 5: asynchronous reset mid-operation aborts it
        bus.dividend = 8'd240;
        bus.divisor  = 4'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_ready", 32'(bus.ready), 32'd1);
        check_res("t5_rst", 8'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(8'd240, 4'd7, cyc);
        check_res("t5", 8'd34, 4'd2, 1'b0);

        // 6: exhaustive, start held high the whole time
        stuck = 1'b0;
        bus.start = 1'b1;
        for (int a = 0; a < 256 && !stuck; a++) begin
            for (int b = 1; b < 16 && !stuck; b++) begin
                bus.dividend = 8'(a);
                bus.divisor  = 4'(b);
                @(posedge clk);
                @(negedge clk);
                cyc = 0;
                while (!bus.ready && cyc < 40) begin
                    @(negedge clk);
                    cyc++;
                end
                if (!bus.ready) begin
                    stuck = 1'b1;
                    check($sformatf("t6_ready_%0d/%0d", a, b), 32'(bus.ready), 32'd1);
                end else begin
                    check($sformatf("t6_%0d/%0d_qr", a, b),
                          {20'd0, bus.quotient, bus.remainder},
                          {20'd0, 8'(a / b), 4'(a % b)});
                end
            end
        end
        bus.start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
